// File: rtl/logic_op_identifier.sv
// logic_op_identifier: observes (a, b, y) samples of an unknown 2-input gate
// and identifies it as AND, OR, XOR or constant-0.
// Build option: define LOGIC_OP_ID_EARLY_EXIT_EN to end collection as soon as
// two samples for the same input pair disagree.
module logic_op_identifier #(
  parameter int MAX_SAMPLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic       a,
  input  logic       b,
  input  logic       y,
  output logic       in_ready,
  output logic       busy,
  output logic       done,
  output logic [1:0] mode,
  output logic       unknown
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_REPORT} state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_SAMPLES);

  state_t     r_state, w_state_nxt;
  logic [3:0] r_seen, r_table;
  logic [7:0] r_cnt;
  logic       r_conf;
  logic [1:0] r_mode;
  logic       r_unknown;

  logic       w_xfer, w_start_ok, w_finish, w_hit_conf;
  logic [1:0] w_idx;
  logic [3:0] w_seen_nxt, w_table_nxt;
  logic [7:0] w_cnt_nxt;
  logic       w_conf_nxt;
  logic [1:0] w_mode;
  logic       w_unknown;

  assign w_idx      = {a, b};
  assign w_xfer     = in_valid && (r_state == S_COLLECT);
  assign w_start_ok = start && (r_state != S_COLLECT);

  // Fold the current transfer into the collected tables; the verdict is
  // decoded from these so the final sample counts on the REPORT-entry edge.
  always_comb begin
    w_seen_nxt  = r_seen;
    w_table_nxt = r_table;
    w_cnt_nxt   = r_cnt;
    w_hit_conf  = 1'b0;
    if (w_xfer) begin
      w_seen_nxt[w_idx] = 1'b1;
      w_cnt_nxt         = r_cnt + 8'd1;
      // First observation wins; later disagreement only raises the conflict.
      if (!r_seen[w_idx]) w_table_nxt[w_idx] = y;
      else                w_hit_conf         = (r_table[w_idx] != y);
    end
    w_conf_nxt = r_conf || w_hit_conf;
  end

  // Collection ends on full coverage, sample limit, or (optionally) conflict.
  always_comb begin
`ifdef LOGIC_OP_ID_EARLY_EXIT_EN
    w_finish = w_xfer && ((w_seen_nxt == 4'b1111) || (w_cnt_nxt == MAX_CNT) || w_conf_nxt);
`else
    w_finish = w_xfer && ((w_seen_nxt == 4'b1111) || (w_cnt_nxt == MAX_CNT));
`endif
  end

  // Verdict decode; table bit idx = {a,b}, so bit 3 is ab=11.
  always_comb begin
    w_mode    = 2'd3;
    w_unknown = 1'b1;
    if (!w_conf_nxt && (w_seen_nxt == 4'b1111)) begin
      unique case (w_table_nxt)
        4'b1000: begin w_mode = 2'd0; w_unknown = 1'b0; end
        4'b1110: begin w_mode = 2'd1; w_unknown = 1'b0; end
        4'b0110: begin w_mode = 2'd2; w_unknown = 1'b0; end
        4'b0000: begin w_mode = 2'd3; w_unknown = 1'b0; end
        default: begin w_mode = 2'd3; w_unknown = 1'b1; end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; start is ignored while collecting.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_state_nxt = S_COLLECT;
      S_COLLECT: if (w_finish) w_state_nxt = S_REPORT;
      S_REPORT:  w_state_nxt = start ? S_COLLECT : S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs decoded from state; REPORT lasts one cycle so done is a pulse.
  always_comb begin
    in_ready = (r_state == S_COLLECT);
    busy     = (r_state == S_COLLECT);
    done     = (r_state == S_REPORT);
    mode     = r_mode;
    unknown  = r_unknown;
  end

  // Collection datapath and verdict registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen    <= 4'd0;
      r_table   <= 4'd0;
      r_cnt     <= 8'd0;
      r_conf    <= 1'b0;
      r_mode    <= 2'd3;
      r_unknown <= 1'b1;
    end else if (w_start_ok) begin
      r_seen    <= 4'd0;
      r_table   <= 4'd0;
      r_cnt     <= 8'd0;
      r_conf    <= 1'b0;
      r_mode    <= 2'd3;
      r_unknown <= 1'b1;
    end else if (r_state == S_COLLECT) begin
      r_seen  <= w_seen_nxt;
      r_table <= w_table_nxt;
      r_cnt   <= w_cnt_nxt;
      r_conf  <= w_conf_nxt;
      if (w_finish) begin
        r_mode    <= w_mode;
        r_unknown <= w_unknown;
      end
    end
  end

endmodule
